// File: rtl/rx_dword_aligner_256.sv
// rtl/rx_dword_aligner_256.sv - strips the start offset from RX payload beats and emits LSB-aligned dwords
// with per-packet length tracking, done/error pulses and a deferred flush pulse for the downstream packer.
module rx_dword_aligner_256 #(
  parameter int C_LEN_WIDTH = 10
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [255:0]           RX_DATA,
  input  logic                   RX_DATA_VALID,
  input  logic                   RX_DATA_START,
  input  logic [2:0]             RX_DATA_START_OFFSET,
  input  logic [C_LEN_WIDTH-1:0] RX_DATA_LEN,
  input  logic                   RX_DATA_END,
  input  logic                   RX_FLUSH_REQ,
  output logic [255:0]           DATA_OUT,
  output logic [3:0]             DATA_OUT_EN,
  output logic                   DATA_OUT_DONE,
  output logic                   DATA_OUT_ERR,
  output logic                   DATA_OUT_FLUSH
);

  localparam int RW = C_LEN_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t          r_state;
  logic [RW-1:0]   r_remain;
  logic            r_flush_pend;

  logic            w_start_acc;
  logic            w_cont_acc;
  logic [2:0]      w_lo;
  logic [3:0]      w_cap;
  logic [RW-1:0]   w_len;
  logic [RW-1:0]   w_avail;
  logic [3:0]      w_take;
  logic [RW-1:0]   w_rem_next;
  logic [255:0]    w_shifted;
  logic [255:0]    w_masked;
  logic            w_flush_go;

  assign w_start_acc = RX_DATA_VALID & RX_DATA_START & (r_state == S_IDLE);
  assign w_cont_acc  = RX_DATA_VALID & ~RX_DATA_START & (r_state == S_ACTIVE);
  assign w_lo        = w_start_acc ? RX_DATA_START_OFFSET : 3'd0;
  assign w_cap       = 4'd8 - {1'b0, w_lo};
  // A zero length field means the full 2^C_LEN_WIDTH dwords, i.e. just the carry bit set.
  assign w_len       = {(RX_DATA_LEN == '0), RX_DATA_LEN};
  assign w_avail     = w_start_acc ? w_len : r_remain;
  assign w_take      = (w_avail < RW'(w_cap)) ? w_avail[3:0] : w_cap;
  assign w_rem_next  = w_avail - RW'(w_take);
  assign w_shifted   = RX_DATA >> {w_lo, 5'd0};

  always_comb begin
    w_masked = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(w_take)) w_masked[32*i +: 32] = w_shifted[32*i +: 32];
    end
  end

  // A start beat in IDLE may complete a packet this cycle, so it blocks the flush.
  assign w_flush_go = r_flush_pend & (r_state == S_IDLE) & ~(RX_DATA_VALID & RX_DATA_START);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state        <= S_IDLE;
      r_remain       <= '0;
      r_flush_pend   <= 1'b0;
      DATA_OUT       <= '0;
      DATA_OUT_EN    <= '0;
      DATA_OUT_DONE  <= 1'b0;
      DATA_OUT_ERR   <= 1'b0;
      DATA_OUT_FLUSH <= 1'b0;
    end else begin
      DATA_OUT       <= '0;
      DATA_OUT_EN    <= '0;
      DATA_OUT_DONE  <= 1'b0;
      DATA_OUT_ERR   <= 1'b0;
      DATA_OUT_FLUSH <= w_flush_go;
      r_flush_pend   <= w_flush_go ? RX_FLUSH_REQ : (r_flush_pend | RX_FLUSH_REQ);

      if (w_start_acc || w_cont_acc) begin
        DATA_OUT    <= w_masked;
        DATA_OUT_EN <= w_take;
        r_remain    <= w_rem_next;
        if (w_rem_next == '0) begin
          DATA_OUT_DONE <= 1'b1;
          DATA_OUT_ERR  <= ~RX_DATA_END;
          r_state       <= RX_DATA_END ? S_IDLE : S_DRAIN;
        end else if (RX_DATA_END) begin
          DATA_OUT_DONE <= 1'b1;
          DATA_OUT_ERR  <= 1'b1;
          r_state       <= S_IDLE;
        end else begin
          r_state <= S_ACTIVE;
        end
      end else if (RX_DATA_VALID) begin
        case (r_state)
          S_ACTIVE: begin
            DATA_OUT_DONE <= 1'b1;
            DATA_OUT_ERR  <= 1'b1;
            r_state       <= S_IDLE;
          end
          S_DRAIN: begin
            if (RX_DATA_END) r_state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_dword_aligner_256.sv
// tb/tb_rx_dword_aligner_256.sv - directed scoreboard bench for rx_dword_aligner_256
module tb_rx_dword_aligner_256;

  logic         CLK;
  logic         RST_N;
  logic [255:0] RX_DATA;
  logic         RX_DATA_VALID;
  logic         RX_DATA_START;
  logic [2:0]   RX_DATA_START_OFFSET;
  logic [9:0]   RX_DATA_LEN;
  logic         RX_DATA_END;
  logic         RX_FLUSH_REQ;
  logic [255:0] DATA_OUT;
  logic [3:0]   DATA_OUT_EN;
  logic         DATA_OUT_DONE;
  logic         DATA_OUT_ERR;
  logic         DATA_OUT_FLUSH;

  rx_dword_aligner_256 dut (
    .CLK                  (CLK),
    .RST_N                (RST_N),
    .RX_DATA              (RX_DATA),
    .RX_DATA_VALID        (RX_DATA_VALID),
    .RX_DATA_START        (RX_DATA_START),
    .RX_DATA_START_OFFSET (RX_DATA_START_OFFSET),
    .RX_DATA_LEN          (RX_DATA_LEN),
    .RX_DATA_END          (RX_DATA_END),
    .RX_FLUSH_REQ         (RX_FLUSH_REQ),
    .DATA_OUT             (DATA_OUT),
    .DATA_OUT_EN          (DATA_OUT_EN),
    .DATA_OUT_DONE        (DATA_OUT_DONE),
    .DATA_OUT_ERR         (DATA_OUT_ERR),
    .DATA_OUT_FLUSH       (DATA_OUT_FLUSH)
  );

  typedef struct {
    logic [255:0] data;
    logic [3:0]   en;
    logic         done;
    logic         err;
    logic         flush;
  } exp_t;

  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;
  string step  = "init";

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%h expected=%h", step, tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference alignment: output dword i is input dword lo+i for the first n dwords.
  function automatic logic [255:0] exp_data(input logic [255:0] d, input int lo, input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[32*i +: 32] = d[32*(lo+i) +: 32];
    return r;
  endfunction

  task automatic drv(input logic v, input logic s, input logic [2:0] off,
                     input logic [9:0] len, input logic e, input logic f);
    RX_DATA              = rnd256();
    RX_DATA_VALID        = v;
    RX_DATA_START        = s;
    RX_DATA_START_OFFSET = off;
    RX_DATA_LEN          = len;
    RX_DATA_END          = e;
    RX_FLUSH_REQ         = f;
  endtask

  task automatic push(input logic [255:0] d, input logic [3:0] en, input logic done,
                      input logic err, input logic fl);
    exp_t x;
    x.data = d; x.en = en; x.done = done; x.err = err; x.flush = fl;
    sb.push_back(x);
  endtask

  task automatic push0();
    push('0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    exp_t x;
    @(posedge CLK);
    #1;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s/sb_underflow observed=0 expected=1", step);
    end
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("data",  DATA_OUT,       x.data);
      chk("en",    DATA_OUT_EN,    x.en);
      chk("done",  DATA_OUT_DONE,  x.done);
      chk("err",   DATA_OUT_ERR,   x.err);
      chk("flush", DATA_OUT_FLUSH, x.flush);
    end
  endtask

  task automatic chk_all_zero();
    chk("data",  DATA_OUT,       '0);
    chk("en",    DATA_OUT_EN,    '0);
    chk("done",  DATA_OUT_DONE,  '0);
    chk("err",   DATA_OUT_ERR,   '0);
    chk("flush", DATA_OUT_FLUSH, '0);
  endtask

  initial begin
    RST_N = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    #12;
    step = "reset";
    chk_all_zero();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    step = "post_release";
    drv(0, 0, 0, 0, 0, 0); push0(); tick();

    step = "off3_len5";
    drv(1, 1, 3, 5, 1, 0); push(exp_data(RX_DATA, 3, 5), 5, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0); push0(); tick();

    step = "len20_off2";
    drv(1, 1, 2, 20, 0, 0); push(exp_data(RX_DATA, 2, 6), 6, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 1, 0); push0(); tick();
    drv(1, 0, 0, 0, 0, 0); push(exp_data(RX_DATA, 0, 8), 8, 0, 0, 0); tick();
    drv(1, 0, 0, 0, 1, 0); push(exp_data(RX_DATA, 0, 6), 6, 1, 0, 0); tick();

    step = "len4_no_end";
    drv(1, 1, 0, 4, 0, 0); push(exp_data(RX_DATA, 0, 4), 4, 1, 1, 0); tick();
    drv(1, 0, 0, 0, 0, 0); push0(); tick();
    drv(1, 0, 0, 0, 1, 0); push0(); tick();
    step = "idle_nonstart";
    drv(1, 0, 0, 0, 1, 0); push0(); tick();
    step = "off7_len1";
    drv(1, 1, 7, 1, 1, 0); push(exp_data(RX_DATA, 7, 1), 1, 1, 0, 0); tick();

    step = "len16_early_end";
    drv(1, 1, 0, 16, 1, 0); push(exp_data(RX_DATA, 0, 8), 8, 1, 1, 0); tick();
    step = "start_abort";
    drv(1, 1, 0, 16, 0, 0); push(exp_data(RX_DATA, 0, 8), 8, 0, 0, 0); tick();
    drv(1, 1, 5, 3, 1, 0); push0(); sb[sb.size()-1].done = 1'b1; sb[sb.size()-1].err = 1'b1; tick();
    drv(1, 0, 0, 0, 1, 0); push0(); tick();

    step = "len0_full";
    drv(1, 1, 0, 0, 0, 0); push(exp_data(RX_DATA, 0, 8), 8, 0, 0, 0); tick();
    for (int i = 1; i < 128; i++) begin
      drv(1, 0, 0, 0, (i == 127), 0);
      push(exp_data(RX_DATA, 0, 8), 8, (i == 127), 0, 0);
      tick();
    end

    step = "flush_active";
    drv(1, 1, 4, 12, 0, 1); push(exp_data(RX_DATA, 4, 4), 4, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 1); push0(); tick();
    drv(1, 0, 0, 0, 1, 0); push(exp_data(RX_DATA, 0, 8), 8, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0); push('0, 0, 0, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0); push0(); tick();

    step = "flush_idle";
    drv(0, 0, 0, 0, 0, 1); push0(); tick();
    drv(0, 0, 0, 0, 0, 0); push('0, 0, 0, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0); push0(); tick();

    step = "flush_repeat";
    drv(0, 0, 0, 0, 0, 1); push0(); tick();
    drv(0, 0, 0, 0, 0, 1); push('0, 0, 0, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0); push('0, 0, 0, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0); push0(); tick();

    step = "flush_vs_start";
    drv(0, 0, 0, 0, 0, 1); push0(); tick();
    drv(1, 1, 0, 8, 1, 0); push(exp_data(RX_DATA, 0, 8), 8, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0); push('0, 0, 0, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0); push0(); tick();

    step = "reset_mid_packet";
    drv(1, 1, 0, 20, 0, 1); push(exp_data(RX_DATA, 0, 8), 8, 0, 0, 0); tick();
    drv(1, 0, 0, 0, 0, 0);
    #1;
    RST_N = 1'b0;
    #1;
    chk_all_zero();
    @(posedge CLK);
    #1;
    chk_all_zero();
    RST_N = 1'b1;
    drv(1, 0, 0, 0, 1, 0); push0(); tick();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0); push0(); tick();
    end

    step = "end";
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL %s/sb_leftover observed=%0d expected=0", step, sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_dword_aligner_256.md
RX_DWORD_ALIGNER_256 -- requirements
Module: rx_dword_aligner_256

Interface
REQ-001 SHALL have parameter C_LEN_WIDTH, default 10, width of the payload dword-length field; length 0 encodes 2^C_LEN_WIDTH dwords.
REQ-002 SHALL have ports:
  CLK  in  1  sole clock; all state on rising edge.
  RST_N  in  1  asynchronous, active-low reset.
  RX_DATA  in  256  payload beat; dword i = bits [32i+31:32i].
  RX_DATA_VALID  in  1  beat qualifier.
  RX_DATA_START  in  1  first beat of packet (qualified by VALID).
  RX_DATA_START_OFFSET  in  3  dword index of first valid dword on start beat.
  RX_DATA_LEN  in  C_LEN_WIDTH  packet dword length, sampled on start beat.
  RX_DATA_END  in  1  last beat of packet (qualified by VALID).
  RX_FLUSH_REQ  in  1  single-cycle request to flush downstream packer.
  DATA_OUT  out  256  LSB-aligned dwords; unused upper dwords zero.
  DATA_OUT_EN  out  4  number of valid dwords in DATA_OUT, 0..8.
  DATA_OUT_DONE  out  1  one-cycle pulse, packet ended.
  DATA_OUT_ERR  out  1  one-cycle pulse with DONE, packet malformed.
  DATA_OUT_FLUSH  out  1  one-cycle flush pulse to packer.

Function
REQ-003 SHALL implement states IDLE, ACTIVE, DRAIN and an 11-bit remaining-dword counter rRemain.
REQ-004 SHALL register all outputs; latency from accepted input beat to output = 1 cycle.
REQ-005 IDLE, VALID&START: lo=START_OFFSET, len=LEN (0 -> 2^C_LEN_WIDTH), take=min(8-lo,len), rRemain=len-take.
REQ-006 ACTIVE, VALID & !START: lo=0, take=min(8,rRemain), rRemain-=take.
REQ-007 Accepted beat SHALL drive DATA_OUT = (RX_DATA >> 32*lo) with dwords >= take zeroed, DATA_OUT_EN = take.
REQ-008 rRemain reaching 0 with END on same beat: DONE=1, ERR=0, next state IDLE.
REQ-009 rRemain reaching 0 without END: DONE=1, ERR=1, next state DRAIN.
REQ-010 END with rRemain>0 after the beat: DONE=1, ERR=1, next state IDLE; that beat's take dwords still output.
REQ-011 ACTIVE, VALID&START: old packet aborted; beat discarded (EN=0); DONE=1, ERR=1; next state IDLE.
REQ-012 DRAIN: all valid beats discarded, no DONE; VALID&END -> IDLE.
REQ-013 IDLE, VALID & !START: beat discarded, no DONE/ERR, stay IDLE.
REQ-014 VALID low: EN=0, DONE=0, ERR=0, state/rRemain unchanged.
REQ-015 EN=0 SHALL force DATA_OUT=0.
REQ-016 RX_FLUSH_REQ SHALL set pending flag rFlushPend (sticky; repeated requests merge into one).
REQ-017 DATA_OUT_FLUSH SHALL assert one cycle after a cycle where rFlushPend=1, state=IDLE, no start beat accepted and no DONE being generated; rFlushPend then cleared.
REQ-018 Consequence: FLUSH never coincides with DONE; earliest FLUSH is the cycle after packet DONE.
REQ-019 Request in same cycle as FLUSH generation SHALL stay pending and produce a second FLUSH later.
REQ-020 Pending flush SHALL be held through ACTIVE/DRAIN; new start beats are accepted normally while pending.

Reset
REQ-021 RST_N low SHALL asynchronously force state IDLE, rRemain=0, rFlushPend=0, DATA_OUT=0, DATA_OUT_EN=0, DONE=0, ERR=0, FLUSH=0.
REQ-022 Reset mid-packet SHALL abandon the packet with no DONE/ERR emitted; first post-reset beat requires START.
REQ-023 Deassertion SHALL take effect on next CLK edge; no output pulses in first cycle after release.

Verification
REQ-024 Start beat, offset 3, LEN=5, END -> one cycle later EN=5, DATA_OUT dwords0..4 = input dwords3..7, DONE=1, ERR=0.
REQ-025 LEN=20, offset 2, beats 1-3, END on beat 3 -> EN=6,8,6; DONE on third output; upper two dwords of last output zero.
REQ-026 LEN=4, offset 0, no END -> EN=4, DONE=1, ERR=1; next two beats (END on second) -> EN=0, no DONE; then IDLE.
REQ-027 LEN=16, END on first beat -> EN=8, DONE=1, ERR=1; START mid-packet -> EN=0, DONE=1, ERR=1.
REQ-028 FLUSH_REQ during ACTIVE -> FLUSH exactly one cycle after DONE; FLUSH_REQ in IDLE -> FLUSH next cycle.
REQ-029 RST_N low while ACTIVE with rRemain=12 and flush pending -> all outputs 0 immediately; no FLUSH or DONE after release.
